// File: rtl/apb_initiator_pkg.sv
// Shared APB definitions: bus width defaults, initiator state encoding and
// the register map used by the peripherals behind this initiator.
package sl_apb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam logic [15:0] CONFIG_ADDR  = 16'h0001;
  localparam logic [15:0] DATA_ADDR    = 16'h0002;
  localparam logic [15:0] STATUS_ADDR  = 16'h0003;
  localparam logic [15:0] CHANNEL_ADDR = 16'h0004;

endpackage

// File: rtl/apb_initiator_if.sv
// APB bus bundle between the initiator (master) and a completer (slave).
interface apb_initiator_if
  import sl_apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_initiator_wait_timer.sv
// Saturating wait-state counter with a terminal compare against LIMIT.
// expire is asserted in the wait cycle whose increment brings the count to LIMIT.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

  logic [7:0] count;

  // Clear on transfer start, count wait cycles, hold at all-ones instead of wrapping.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expire = inc && (count == LIMIT_M1);

endmodule

// File: rtl/apb_initiator.sv
// APB initiator: turns a valid/ready command into one APB transfer and holds
// the result on a valid/ready response port.
// Optional wait-state timeout abort: define APB_INITIATOR_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a command, cmd_ready high
// ST_SETUP  | APB setup phase, psel=1 penable=0
// ST_ACCESS | APB access phase, waiting for pready (or timeout)
// ST_RESP   | response held until rsp_ready
module apb_initiator
  import sl_apb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  apb_initiator_if.master   apb
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_initiator: TIMEOUT_CYCLES must be within 1..255");
  end

  apb_state_t state;
  logic       accept;

  assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

`ifdef APB_INITIATOR_TIMEOUT_EN
  logic tmo_expire;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .pclk     (pclk),
    .preset_n (preset_n),
    .clear    (accept),
    .inc      ((state == ST_ACCESS) && !apb.pready),
    .expire   (tmo_expire)
  );
`else
  assign rsp_timeout = 1'b0;
`endif

  // Transfer sequencing; every port output is a register updated here.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
`ifdef APB_INITIATOR_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
      apb.paddr   <= '0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.pwdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // The APB address/data registers double as the command latch.
            apb.paddr  <= cmd_addr;
            apb.pwrite <= cmd_write;
            apb.pwdata <= cmd_wdata;
            apb.psel   <= 1'b1;
            cmd_ready  <= 1'b0;
            state      <= ST_SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          apb.penable <= 1'b1;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (apb.pready) begin
            rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
            rsp_err     <= apb.pslverr;
`ifdef APB_INITIATOR_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            rsp_valid   <= 1'b1;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            state       <= ST_RESP;
          end
`ifdef APB_INITIATOR_TIMEOUT_EN
          else if (tmo_expire) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            state       <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: expected responses are queued when a
// command is driven and compared when the response appears.
module tb_apb_initiator;
  import sl_apb_pkg::*;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  apb_initiator_if #(.ADDR_W(16), .DATA_W(32)) apb ();

  apb_initiator #(
    .ADDR_W         (16),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one command from a negedge, plays the completer with wait_n wait
  // states, then holds rsp_ready low for hold cycles (offering a second
  // command meanwhile) before consuming the response.
  task automatic run_cmd(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input int wait_n, input logic [31:0] rdata,
                         input logic slverr, input bit exp_tmo, input int exp_lat, input int hold);
    rsp_t        exp;
    rsp_t        got;
    int          lat;
    logic [31:0] rd_q;
    logic        err_q;
    logic        tmo_q;
    exp.rdata = (exp_tmo || wr) ? 32'h0 : rdata;
    exp.err   = exp_tmo ? 1'b1 : slverr;
    exp.tmo   = exp_tmo;
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1'b1));
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    sb.push_back(exp);
    lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge pclk);
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        check({tag, "_setup_psel"}, 64'(apb.psel), 64'(1'b1));
        check({tag, "_setup_penable"}, 64'(apb.penable), 64'(1'b0));
        check({tag, "_pwrite"}, 64'(apb.pwrite), 64'(wr));
        check({tag, "_pwdata"}, 64'(apb.pwdata), 64'(wdata));
      end
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      if (cyc >= 2) begin
        check({tag, "_access_psel"}, 64'(apb.psel), 64'(1'b1));
        check({tag, "_access_penable"}, 64'(apb.penable), 64'(1'b1));
      end
      check({tag, "_paddr"}, 64'(apb.paddr), 64'(addr));
      if (cyc >= 2 + wait_n) begin
        apb.pready  = 1'b1;
        apb.prdata  = rdata;
        apb.pslverr = slverr;
      end else begin
        apb.pready  = 1'b0;
        apb.prdata  = 32'hDEAD_BEEF;
        apb.pslverr = 1'b1;
      end
    end
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (lat > 0) begin
      got = sb.pop_front();
      check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(got.rdata));
      check({tag, "_rsp_err"}, 64'(rsp_err), 64'(got.err));
      check({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(got.tmo));
      check({tag, "_resp_psel"}, 64'(apb.psel), 64'(1'b0));
      check({tag, "_resp_penable"}, 64'(apb.penable), 64'(1'b0));
      rd_q  = rsp_rdata;
      err_q = rsp_err;
      tmo_q = rsp_timeout;
      for (int h = 0; h < hold; h++) begin
        if (h == 0) begin
          cmd_valid = 1'b1;
          cmd_write = 1'b0;
          cmd_addr  = CHANNEL_ADDR;
        end
        @(negedge pclk);
        check({tag, "_hold_valid"}, 64'(rsp_valid), 64'(1'b1));
        check({tag, "_hold_rdata"}, 64'(rsp_rdata), 64'(rd_q));
        check({tag, "_hold_err"}, 64'({rsp_err, rsp_timeout}), 64'({err_q, tmo_q}));
        check({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 64'(1'b0));
        check({tag, "_hold_psel"}, 64'(apb.psel), 64'(1'b0));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
      check({tag, "_done_valid"}, 64'(rsp_valid), 64'(1'b0));
      check({tag, "_done_cmd_ready"}, 64'(cmd_ready), 64'(1'b1));
      check({tag, "_done_paddr_kept"}, 64'(apb.paddr), 64'(addr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    apb.pready  = 1'b0;
    apb.prdata  = 32'h0;
    apb.pslverr = 1'b0;

    // Reset values
    @(negedge pclk);
    @(negedge pclk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(32'h0));
    check("rst_rsp_flags", 64'({rsp_err, rsp_timeout}), 64'(2'b00));
    check("rst_apb_ctrl", 64'({apb.psel, apb.penable, apb.pwrite}), 64'(3'b000));
    check("rst_paddr", 64'(apb.paddr), 64'(16'h0));
    check("rst_pwdata", 64'(apb.pwdata), 64'(32'h0));
    preset_n = 1'b1;
    #1 check("rel_cmd_ready_low", 64'(cmd_ready), 64'(1'b0));
    @(negedge pclk);

    run_cmd("wr_config", 1'b1, CONFIG_ADDR, 32'h0000_00A5, 0, 32'h5555_5555, 1'b0, 1'b0, 3, 0);
    run_cmd("rd_status", 1'b0, STATUS_ADDR, 32'h0, 3, 32'h0000_0108, 1'b0, 1'b0, 6, 0);
    run_cmd("rd_slverr", 1'b0, 16'h0007, 32'h0, 1, 32'h0000_1234, 1'b1, 1'b0, 4, 0);
    run_cmd("wr_hold", 1'b1, DATA_ADDR, 32'hCAFE_0042, 2, 32'h0, 1'b0, 1'b0, 5, 5);
    run_cmd("rd_second", 1'b0, CHANNEL_ADDR, 32'h0, 0, 32'h8765_4321, 1'b0, 1'b0, 3, 1);

`ifdef APB_INITIATOR_TIMEOUT_EN
    run_cmd("rd_timeout", 1'b0, STATUS_ADDR, 32'h0, 1000, 32'h0, 1'b0, 1'b1, 18, 0);
    run_cmd("rd_pready_wins", 1'b0, DATA_ADDR, 32'h0, 15, 32'h0000_0F0F, 1'b0, 1'b0, 18, 0);
`else
    run_cmd("rd_long_wait", 1'b0, STATUS_ADDR, 32'h0, 20, 32'h0000_0777, 1'b0, 1'b0, 23, 0);
`endif

    // Reset in the middle of an ACCESS phase
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0005;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("mid_in_access", 64'({apb.psel, apb.penable}), 64'(2'b11));
    #2 preset_n = 1'b0;
    #1;
    check("mid_rst_psel_penable", 64'({apb.psel, apb.penable}), 64'(2'b00));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
    check("mid_rst_paddr", 64'(apb.paddr), 64'(16'h0));
    @(negedge pclk);
    preset_n    = 1'b1;
    apb.pready  = 1'b1;
    apb.prdata  = 32'h1111_2222;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      check("post_rst_no_rsp", 64'({rsp_valid, apb.psel}), 64'(2'b00));
    end
    apb.pready = 1'b0;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));

    run_cmd("rd_after_rst", 1'b0, CONFIG_ADDR, 32'h0, 2, 32'h0000_ABCD, 1'b0, 1'b0, 5, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 Parameter ADDR_W, default 16: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS wait cycles before abort; range 1..255.
REQ-004 pclk  in  1  single clock; all logic on rising edge.
REQ-005 preset_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-007 cmd_write  in  1  1 = write, 0 = read; cmd_addr  in  ADDR_W; cmd_wdata  in  DATA_W.
REQ-008 rsp_valid  out  1  response held; rsp_ready  in  1  response consumed when both high.
REQ-009 rsp_rdata  out  DATA_W  read data, 0 for writes; rsp_err  out  1  slave error or timeout; rsp_timeout  out  1  timeout abort.
REQ-010 paddr  out  ADDR_W; psel  out  1; penable  out  1; pwrite  out  1; pwdata  out  DATA_W.
REQ-011 pready  in  1; prdata  in  DATA_W; pslverr  in  1.

Function
REQ-012 The block SHALL have exactly four states: IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-013 cmd_ready SHALL be 1 only in IDLE; an accept latches cmd_write/addr/wdata and moves to SETUP.
REQ-014 SETUP (one cycle): psel=1, penable=0, paddr/pwrite/pwdata driven from latched command; next state ACCESS.
REQ-015 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata SHALL stay unchanged until the transfer ends.
REQ-016 In ACCESS with pready=1: capture prdata (read) or 0 (write) into rsp_rdata, pslverr into rsp_err, rsp_timeout=0, drop psel/penable, go RESP.
REQ-017 pslverr and prdata SHALL be ignored unless penable=1 and pready=1.
REQ-018 Latency: accept at edge N -> SETUP cycle N+1 -> ACCESS N+2 -> rsp_valid=1 at N+3 when pready=1 in first ACCESS cycle; each wait state adds one cycle.
REQ-019 RESP: rsp_valid=1 with stable rsp_* until rsp_ready=1; then rsp_valid=0 and IDLE next cycle; no new command accepted while in RESP.
REQ-020 Outside SETUP/ACCESS psel=0 and penable=0; paddr/pwdata retain the last value; pwrite retains last value.
REQ-021 Wait-state counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0; it SHALL not wrap.

Reset
REQ-022 On preset_n=0 immediately: state IDLE, cmd_ready=0 until first edge after release then 1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, paddr=0, psel=0, penable=0, pwrite=0, pwdata=0, counter=0.
REQ-023 Reset mid-transfer SHALL discard the in-flight command with no response produced.

Configuration
REQ-024 Macro APB_INITIATOR_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES in ACCESS with pready=0, the transfer SHALL abort (psel=penable=0), RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-025 pready=1 in the same cycle the limit is reached SHALL complete normally (pready wins).
REQ-026 Macro undefined: no abort, ACCESS waits indefinitely, rsp_timeout tied 0, counter logic absent.

Structure
REQ-027 Shared package sl_apb_pkg SHALL hold ADDR_W/DATA_W defaults, state encoding, register addresses CONFIG_ADDR=1, DATA_ADDR=2, STATUS_ADDR=3, CHANNEL_ADDR=4.
REQ-028 One sub-module apb_wait_timer (saturating counter with limit compare) SHALL be instantiated only under APB_INITIATOR_TIMEOUT_EN.

Verification
REQ-029 Write addr 0x0001 data 0x000000A5, pready=1 immediately -> psel=1 cycles N+1..N+2, penable=1 at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-030 Read addr 0x0003, pready low 3 ACCESS cycles then high with prdata=0x00000108 -> rsp_valid at N+6, rsp_rdata=0x00000108, paddr stable throughout.
REQ-031 Read addr 0x0007 with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0.
REQ-032 Macro defined, TIMEOUT_CYCLES=16, pready never high -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, psel=0.
REQ-033 rsp_ready low 5 cycles in RESP -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted until IDLE.
REQ-034 preset_n low during ACCESS -> psel/penable/rsp_valid 0 asynchronously, no response after release.
